// File: rtl/raster_pkg.sv
// Shared encodings and screen defaults for the raster walker.
// Mode values, FSM state type and the default visible screen size.
package raster_pkg;

    localparam logic [1:0] MODE_FULL   = 2'b00;
    localparam logic [1:0] MODE_SPR    = 2'b01;
    localparam logic [1:0] MODE_MIRROR = 2'b10;

    localparam int SCREEN_W_DEF = 160;
    localparam int SCREEN_H_DEF = 120;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/raster_counter.sv
// Column/row counters for the raster walk plus the row-base address accumulator.
// Exposes next-cycle values so the top can register its pixel outputs from them.
module raster_counter #(
    parameter int X_W    = 8,
    parameter int Y_W    = 7,
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              step,
    input  logic [X_W-1:0]    w,
    input  logic [Y_W-1:0]    h,
    output logic [X_W-1:0]    c_d,
    output logic [Y_W-1:0]    r_d,
    output logic [ADDR_W-1:0] row_base_d,
    output logic              last
);

    logic [X_W-1:0]    c_q;
    logic [Y_W-1:0]    r_q;
    logic [ADDR_W-1:0] row_base_q;
    logic              row_end;

    assign row_end = (c_q == w - X_W'(1));
    assign last    = row_end && (r_q == h - Y_W'(1));

    always_comb begin
        c_d        = c_q;
        r_d        = r_q;
        row_base_d = row_base_q;
        if (clear) begin
            c_d        = '0;
            r_d        = '0;
            row_base_d = '0;
        end else if (step) begin
            if (row_end) begin
                c_d        = '0;
                r_d        = r_q + Y_W'(1);
                row_base_d = row_base_q + ADDR_W'(w);
            end else begin
                c_d = c_q + X_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            c_q        <= '0;
            r_q        <= '0;
            row_base_q <= '0;
        end else begin
            c_q        <= c_d;
            r_q        <= r_d;
            row_base_q <= row_base_d;
        end
    end

endmodule

// File: rtl/sprite_raster_walker.sv
// Walks a full-screen or sprite rectangle in raster order, emitting clipped pixel
// coordinates and ROM addresses with a pix_valid/ready handshake toward the VGA path.
module sprite_raster_walker
    import raster_pkg::*;
#(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int SCREEN_H = SCREEN_H_DEF,
    parameter int ADDR_W   = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [X_W-1:0]    x_origin,
    input  logic [Y_W-1:0]    y_origin,
    input  logic [X_W-1:0]    spr_w,
    input  logic [Y_W-1:0]    spr_h,
    input  logic              ready,
    output logic [X_W-1:0]    x,
    output logic [Y_W-1:0]    y,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              pix_valid,
    output logic              busy,
    output logic              done
);

    state_e            state_q, state_d;
    logic [X_W-1:0]    xo_q, xo_d, w_q, w_d;
    logic [Y_W-1:0]    yo_q, yo_d, h_q, h_d;
    logic              mirror_q, mirror_d;
    logic [X_W-1:0]    x_q, x_d;
    logic [Y_W-1:0]    y_q, y_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              pix_valid_q, pix_valid_d;
    logic              busy_q, busy_d, done_q, done_d;

    logic              start_ok, adv, last;
    logic [X_W-1:0]    c_d, col_off;
    logic [Y_W-1:0]    r_d;
    logic [ADDR_W-1:0] row_base_d;
    logic [X_W:0]      x_wide;
    logic [Y_W:0]      y_wide;

    assign start_ok = start && (state_q == S_IDLE);
    // Off-screen pixels never wait for ready; on-screen ones wait for acceptance.
    assign adv      = (state_q == S_RUN) && (!pix_valid_q || ready);

    raster_counter #(.X_W(X_W), .Y_W(Y_W), .ADDR_W(ADDR_W)) u_counter (
        .clk        (clk),
        .reset      (reset),
        .clear      (start_ok),
        .step       (adv && !last),
        .w          (w_q),
        .h          (h_q),
        .c_d        (c_d),
        .r_d        (r_d),
        .row_base_d (row_base_d),
        .last       (last)
    );

    always_comb begin
        xo_d     = xo_q;
        yo_d     = yo_q;
        w_d      = w_q;
        h_d      = h_q;
        mirror_d = mirror_q;
        if (start_ok) begin
            case (mode)
                MODE_FULL: begin
                    xo_d     = '0;
                    yo_d     = '0;
                    w_d      = X_W'(SCREEN_W);
                    h_d      = Y_W'(SCREEN_H);
                    mirror_d = 1'b0;
                end
                MODE_MIRROR: begin
                    xo_d     = x_origin;
                    yo_d     = y_origin;
                    w_d      = spr_w;
                    h_d      = spr_h;
                    mirror_d = 1'b1;
                end
                default: begin
                    xo_d     = x_origin;
                    yo_d     = y_origin;
                    w_d      = spr_w;
                    h_d      = spr_h;
                    mirror_d = 1'b0;
                end
            endcase
        end

        state_d = state_q;
        case (state_q)
            S_IDLE: if (start_ok) state_d = (w_d == '0 || h_d == '0) ? S_DONE : S_RUN;
            S_RUN:  if (adv && last) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from the pixel the counter moves to this edge.
        x_wide      = {1'b0, xo_d} + (X_W+1)'(c_d);
        y_wide      = {1'b0, yo_d} + (Y_W+1)'(r_d);
        col_off     = mirror_d ? (w_d - X_W'(1) - c_d) : c_d;
        x_d         = x_wide[X_W-1:0];
        y_d         = y_wide[Y_W-1:0];
        addr_d      = row_base_d + ADDR_W'(col_off);
        pix_valid_d = (state_d == S_RUN) && (x_wide < (X_W+1)'(SCREEN_W))
                      && (y_wide < (Y_W+1)'(SCREEN_H));
        busy_d      = (state_d == S_RUN);
        done_d      = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            xo_q        <= '0;
            yo_q        <= '0;
            w_q         <= '0;
            h_q         <= '0;
            mirror_q    <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            addr_q      <= '0;
            pix_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            xo_q        <= xo_d;
            yo_q        <= yo_d;
            w_q         <= w_d;
            h_q         <= h_d;
            mirror_q    <= mirror_d;
            x_q         <= x_d;
            y_q         <= y_d;
            addr_q      <= addr_d;
            pix_valid_q <= pix_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign x         = x_q;
    assign y         = y_q;
    assign rom_addr  = addr_q;
    assign pix_valid = pix_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_sprite_raster_walker.sv
// Scoreboard bench for sprite_raster_walker: a reference raster model fills an expected
// queue at start, and every pixel the DUT advances past is popped and compared.
module tb_sprite_raster_walker;

    localparam int PW = 8 + 7 + 15 + 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [7:0]  x_origin = '0;
    logic [6:0]  y_origin = '0;
    logic [7:0]  spr_w = '0;
    logic [6:0]  spr_h = '0;
    logic        ready = 1'b1;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [14:0] rom_addr;
    logic        pix_valid;
    logic        busy;
    logic        done;

    logic [PW-1:0] exp_q[$];
    int n_total = 0;
    int n_bad   = 0;

    sprite_raster_walker dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mode      (mode),
        .x_origin  (x_origin),
        .y_origin  (y_origin),
        .spr_w     (spr_w),
        .spr_h     (spr_h),
        .ready     (ready),
        .x         (x),
        .y         (y),
        .rom_addr  (rom_addr),
        .pix_valid (pix_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check_eq({tag, " x"}, 64'(x), 0);
        check_eq({tag, " y"}, 64'(y), 0);
        check_eq({tag, " rom_addr"}, 64'(rom_addr), 0);
        check_eq({tag, " pix_valid"}, 64'(pix_valid), 0);
        check_eq({tag, " busy"}, 64'(busy), 0);
        check_eq({tag, " done"}, 64'(done), 0);
    endtask

    // Reference walk: explicit multiply for the address, independent of the DUT's accumulator.
    task automatic push_model(input logic [1:0] m, input int xo, input int yo,
                              input int w, input int h, output int npix);
        int ew, eh, exo, eyo, xw, yw, a;
        bit mir, v;
        ew  = (m == 2'b00) ? 160 : w;
        eh  = (m == 2'b00) ? 120 : h;
        exo = (m == 2'b00) ? 0 : xo;
        eyo = (m == 2'b00) ? 0 : yo;
        mir = (m == 2'b10);
        npix = ew * eh;
        exp_q.delete();
        for (int r = 0; r < eh; r++) begin
            for (int c = 0; c < ew; c++) begin
                xw = exo + c;
                yw = eyo + r;
                v  = (xw < 160) && (yw < 120);
                a  = r * ew + (mir ? (ew - 1 - c) : c);
                exp_q.push_back({8'(xw), 7'(yw), 15'(a), v});
            end
        end
    endtask

    // rdy_pat: 0 = always ready, 1 = 0,1,0,1 from the first RUN cycle, 2 = random.
    task automatic walk(input string tag, input logic [1:0] m, input int xo, input int yo,
                        input int w, input int h, input int rdy_pat, input int exp_run,
                        input int abort_at);
        int npix, run_cycles, pops, done_k, last_pop_k, budget;
        bit finished;
        logic [PW-1:0] e;
        push_model(m, xo, yo, w, h, npix);
        budget     = 2 * npix + 20;
        run_cycles = 0;
        pops       = 0;
        done_k     = -1;
        last_pop_k = -1;
        finished   = 1'b0;

        start    = 1'b1;
        mode     = m;
        x_origin = 8'(xo);
        y_origin = 7'(yo);
        spr_w    = 8'(w);
        spr_h    = 7'(h);
        @(posedge clk); #1;
        start    = 1'b0;
        mode     = 2'($urandom_range(0, 3));
        x_origin = 8'($urandom_range(0, 255));
        y_origin = 7'($urandom_range(0, 127));
        spr_w    = 8'($urandom_range(0, 255));
        spr_h    = 7'($urandom_range(0, 127));

        for (int k = 0; k < budget && !finished; k++) begin
            case (rdy_pat)
                0:       ready = 1'b1;
                1:       ready = (k % 2 == 1);
                default: ready = 1'($urandom_range(0, 1));
            endcase
            if (k == 3) start = 1'b1;
            if (k == 4) start = 1'b0;
            @(negedge clk);
            if (done) begin
                done_k   = k;
                finished = 1'b1;
            end else begin
                if (busy) run_cycles++;
                if (busy && (!pix_valid || ready)) begin
                    if (exp_q.size() == 0) begin
                        check_eq({tag, " extra_pixel"}, 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq({tag, " pix{x,y,addr,v}"}, 64'({x, y, rom_addr, pix_valid}), 64'(e));
                    end
                    pops++;
                    last_pop_k = k;
                    if (pops == abort_at) begin
                        start = 1'b0;
                        reset = 1'b1;
                        @(posedge clk); #1;
                        reset = 1'b0;
                        @(negedge clk);
                        check_idle_zero({tag, " after_reset"});
                        for (int j = 0; j < 5; j++) begin
                            @(negedge clk);
                            check_eq({tag, " no_done_after_reset"}, 64'({busy, done, pix_valid}), 0);
                        end
                        exp_q.delete();
                        @(posedge clk); #1;
                        return;
                    end
                end
                @(posedge clk); #1;
            end
        end
        start = 1'b0;

        check_eq({tag, " finished_in_budget"}, 64'(finished), 1);
        if (finished) begin
            check_eq({tag, " done_timing"}, 64'(done_k), (npix == 0) ? 0 : 64'(last_pop_k + 1));
            check_eq({tag, " done_cycle_busy_valid"}, 64'({busy, pix_valid}), 0);
            check_eq({tag, " pixels_left"}, 64'(exp_q.size()), 0);
            check_eq({tag, " pixels_seen"}, 64'(pops), 64'(npix));
            if (exp_run >= 0) check_eq({tag, " run_cycles"}, 64'(run_cycles), 64'(exp_run));
            // A start during the DONE cycle must be dropped.
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            check_eq({tag, " idle_after_done"}, 64'({busy, done}), 0);
            @(posedge clk); #1;
        end
        exp_q.delete();
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check_idle_zero("reset");
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        walk("t1_spr6x6",      2'b01, 36, 30, 6, 6, 0, 36, -1);
        walk("t2_mirror4x2",   2'b10, 90, 30, 4, 2, 0, 8, -1);
        walk("t3_clip",        2'b01, 158, 118, 4, 4, 0, 16, -1);
        walk("t4_backpressure", 2'b01, 10, 20, 3, 3, 1, 18, -1);
        walk("t4b_mode11",     2'b11, 5, 5, 3, 2, 2, -1, -1);
        walk("t5_full",        2'b00, 77, 66, 3, 3, 0, 19200, -1);
        walk("t6_reset_mid",   2'b01, 36, 30, 6, 6, 0, -1, 10);
        walk("t6_zero_w",      2'b01, 36, 30, 0, 5, 0, 0, -1);
        walk("t6_zero_h",      2'b10, 20, 20, 7, 0, 0, 0, -1);
        walk("t7_mirror_bp",   2'b10, 155, 115, 7, 6, 2, -1, -1);
        for (int i = 0; i < 4; i++) begin
            walk("rand", 2'($urandom_range(1, 3)), $urandom_range(0, 255), $urandom_range(0, 127),
                 $urandom_range(0, 12), $urandom_range(0, 10), 2, -1, -1);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
